// File: rtl/mem_bus_router_pkg.sv
// Shared bus field widths and the void-target id helper for the mem_bus router.
package mem_bus_router_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;   // holds MAX_OUTSTANDING up to 15

    // The void responder takes the id one past the last real slave.
    function automatic int void_id(input int nr_slaves);
        return nr_slaves;
    endfunction

endpackage

// File: rtl/mem_bus_void_slave.sv
// Responder for unmapped addresses: answers reads one cycle after acceptance
// and records every void access (address, saturating count, irq pulse).
module mem_bus_void_slave
    import mem_bus_router_pkg::*;
#(
    parameter logic [DATA_W-1:0] VOID_RDATA = '0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              i_acc,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic [15:0]       o_void_cnt,
    output logic [ADDR_W-1:0] o_void_addr,
    output logic              o_void_irq
);

    logic              r_rsp;
    logic              r_irq;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_rsp  <= 1'b0;
            r_irq  <= 1'b0;
            r_cnt  <= '0;
            r_addr <= '0;
        end else begin
            r_rsp <= i_acc & ~i_wr;
            r_irq <= i_acc;
            if (i_acc) begin
                r_addr <= i_addr;
                if (r_cnt != 16'hFFFF)
                    r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_rsp_ready = r_rsp;
    assign o_rsp_rdata = VOID_RDATA;
    assign o_void_cnt  = r_cnt;
    assign o_void_addr = r_addr;
    assign o_void_irq  = r_irq;

endmodule

// File: rtl/mem_bus_router.sv
// 1-master / N-slave router for the CPU mem_cmd/mem_rsp bus: mask/base decode,
// single-owner pipelined reads, and a built-in void responder for unmapped space.
module mem_bus_router
    import mem_bus_router_pkg::*;
#(
    parameter int                          NR_SLAVES       = 4,
    parameter logic [NR_SLAVES*ADDR_W-1:0] SLAVE_BASE      = '0,
    parameter logic [NR_SLAVES*ADDR_W-1:0] SLAVE_MASK      = '0,
    parameter int                          MAX_OUTSTANDING = 4,
    parameter logic [DATA_W-1:0]           VOID_RDATA      = '0
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        m_cmd_valid,
    output logic                        m_cmd_ready,
    input  logic                        m_cmd_wr,
    input  logic                        m_cmd_instr,
    input  logic [ADDR_W-1:0]           m_cmd_addr,
    input  logic [DATA_W-1:0]           m_cmd_wdata,
    input  logic [BE_W-1:0]             m_cmd_be,
    output logic                        m_rsp_ready,
    output logic [DATA_W-1:0]           m_rsp_rdata,
    output logic [NR_SLAVES-1:0]        s_cmd_valid,
    input  logic [NR_SLAVES-1:0]        s_cmd_ready,
    output logic                        s_cmd_wr,
    output logic                        s_cmd_instr,
    output logic [ADDR_W-1:0]           s_cmd_addr,
    output logic [DATA_W-1:0]           s_cmd_wdata,
    output logic [BE_W-1:0]             s_cmd_be,
    input  logic [NR_SLAVES-1:0]        s_rsp_ready,
    input  logic [NR_SLAVES*DATA_W-1:0] s_rsp_rdata,
    output logic [15:0]                 void_cnt,
    output logic [ADDR_W-1:0]           void_addr,
    output logic                        void_irq
);

    localparam int               SEL_W   = $clog2(NR_SLAVES + 1);
    localparam logic [SEL_W-1:0] VOID_ID = SEL_W'(void_id(NR_SLAVES));
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [SEL_W-1:0]  w_sel;
    logic [SEL_W-1:0]  r_rd_owner;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic              w_is_void;
    logic              w_rd_block;
    logic              w_sel_ready;
    logic              w_acc;
    logic              w_rd_acc;
    logic              w_void_rsp;
    logic [DATA_W-1:0] w_void_rdata;
    logic              w_own_rsp;
    logic [DATA_W-1:0] w_own_rdata;

    // Descending scan so the lowest matching slave wins overlaps.
    always_comb begin
        w_sel = VOID_ID;
        for (int i = NR_SLAVES - 1; i >= 0; i--)
            if ((m_cmd_addr & SLAVE_MASK[ADDR_W*i +: ADDR_W]) == SLAVE_BASE[ADDR_W*i +: ADDR_W])
                w_sel = SEL_W'(i);
    end

    assign w_is_void  = (w_sel == VOID_ID);
    assign w_rd_block = ~m_cmd_wr &
                        ((r_rd_cnt == MAX_CNT) | ((r_rd_cnt != '0) & (w_sel != r_rd_owner)));

    always_comb begin
        w_sel_ready = 1'b1;
        s_cmd_valid = '0;
        for (int i = 0; i < NR_SLAVES; i++)
            if (w_sel == SEL_W'(i)) begin
                w_sel_ready    = s_cmd_ready[i];
                s_cmd_valid[i] = m_cmd_valid & ~w_rd_block;
            end
    end

    assign m_cmd_ready = ~w_rd_block & w_sel_ready;
    assign w_acc       = m_cmd_valid & m_cmd_ready;
    assign w_rd_acc    = w_acc & ~m_cmd_wr;

    assign s_cmd_wr    = m_cmd_wr;
    assign s_cmd_instr = m_cmd_instr;
    assign s_cmd_addr  = m_cmd_addr;
    assign s_cmd_wdata = m_cmd_wdata;
    assign s_cmd_be    = m_cmd_be;

    // Only the current read owner may answer; anything else is dropped.
    always_comb begin
        w_own_rsp   = w_void_rsp;
        w_own_rdata = w_void_rdata;
        for (int i = 0; i < NR_SLAVES; i++)
            if (r_rd_owner == SEL_W'(i)) begin
                w_own_rsp   = s_rsp_ready[i];
                w_own_rdata = s_rsp_rdata[DATA_W*i +: DATA_W];
            end
    end

    assign m_rsp_ready = w_own_rsp & (r_rd_cnt != '0);
    assign m_rsp_rdata = w_own_rdata;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_rd_cnt   <= '0;
            r_rd_owner <= '0;
        end else begin
            if (w_rd_acc)
                r_rd_owner <= w_sel;
            if (w_rd_acc && !m_rsp_ready)
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            else if (!w_rd_acc && m_rsp_ready)
                r_rd_cnt <= r_rd_cnt - CNT_W'(1);
        end
    end

    mem_bus_void_slave #(
        .VOID_RDATA (VOID_RDATA)
    ) u_void (
        .clk         (clk),
        .reset_      (reset_),
        .i_acc       (w_acc & w_is_void),
        .i_wr        (m_cmd_wr),
        .i_addr      (m_cmd_addr),
        .o_rsp_ready (w_void_rsp),
        .o_rsp_rdata (w_void_rdata),
        .o_void_cnt  (void_cnt),
        .o_void_addr (void_addr),
        .o_void_irq  (void_irq)
    );

`ifndef SYNTHESIS
    logic w_stray;

    always_comb begin
        w_stray = 1'b0;
        for (int i = 0; i < NR_SLAVES; i++)
            if (s_rsp_ready[i] && ((r_rd_cnt == '0) || (r_rd_owner != SEL_W'(i))))
                w_stray = 1'b1;
    end

    always @(posedge clk) begin
        if (reset_ && (w_stray || $isunknown(m_cmd_valid) ||
            (m_cmd_valid && $isunknown({m_cmd_wr, m_cmd_instr, m_cmd_addr, m_cmd_wdata, m_cmd_be})))) begin
            $error("mem_bus_router: stray slave response or unknown command field");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_router.sv
// Bench for mem_bus_router: directed scenarios plus a random phase, all checked
// against a queue-based model of outstanding reads and void-access bookkeeping.
module tb_mem_bus_router;

    localparam int          NS    = 2;
    localparam int          MAXO  = 4;
    localparam logic [31:0] VDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'hF000_0000};
    localparam logic [31:0] MASK [NS] = '{32'hFFFF_E000, 32'hFFFF_F000};

    logic              clk = 1'b0;
    logic              reset_;
    logic              m_cmd_valid, m_cmd_ready, m_cmd_wr, m_cmd_instr;
    logic [31:0]       m_cmd_addr, m_cmd_wdata;
    logic [3:0]        m_cmd_be;
    logic              m_rsp_ready;
    logic [31:0]       m_rsp_rdata;
    logic [NS-1:0]     s_cmd_valid, s_cmd_ready, s_rsp_ready;
    logic              s_cmd_wr, s_cmd_instr;
    logic [31:0]       s_cmd_addr, s_cmd_wdata;
    logic [3:0]        s_cmd_be;
    logic [NS*32-1:0]  s_rsp_rdata;
    logic [15:0]       void_cnt;
    logic [31:0]       void_addr;
    logic              void_irq;

    mem_bus_router #(
        .NR_SLAVES       (NS),
        .SLAVE_BASE      ({32'hF000_0000, 32'h0000_0000}),
        .SLAVE_MASK      ({32'hFFFF_F000, 32'hFFFF_E000}),
        .MAX_OUTSTANDING (MAXO),
        .VOID_RDATA      (VDATA)
    ) dut (
        .clk(clk), .reset_(reset_),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_wr(m_cmd_wr),
        .m_cmd_instr(m_cmd_instr), .m_cmd_addr(m_cmd_addr), .m_cmd_wdata(m_cmd_wdata),
        .m_cmd_be(m_cmd_be), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
        .s_cmd_instr(s_cmd_instr), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
        .s_cmd_be(s_cmd_be), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .void_cnt(void_cnt), .void_addr(void_addr), .void_irq(void_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t         q_exp[$];       // reads in master order
    rd_t         sq[NS][$];      // per-slave pending responses driving the pins
    int          lat[NS+1];
    int          cyc;
    int          owner;
    logic [15:0] vcnt;
    logic [31:0] vaddr;
    bit          irq_exp;
    bit          last_rsp;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK[i]) == BASE[i]) return i;
        return NS;
    endfunction

    // One bus cycle: drive slave responses, check at negedge, advance the model.
    task automatic tick(output bit acc);
        int            sel;
        bit            blk, srdy, rdy, rsp;
        logic [NS-1:0] sv;
        logic [31:0]   d;
        for (int s = 0; s < NS; s++) begin
            while (sq[s].size() > 0 && sq[s][0].due < cyc) void'(sq[s].pop_front());
            if (sq[s].size() > 0 && sq[s][0].due == cyc) begin
                s_rsp_ready[s]         = 1'b1;
                s_rsp_rdata[32*s +: 32] = sq[s][0].data;
            end else begin
                s_rsp_ready[s]         = 1'b0;
                s_rsp_rdata[32*s +: 32] = $urandom;
            end
        end
        @(negedge clk);
        sel  = decode(m_cmd_addr);
        blk  = !m_cmd_wr && (q_exp.size() == MAXO || (q_exp.size() != 0 && sel != owner));
        srdy = 1'b1;
        if (sel < NS) srdy = s_cmd_ready[sel];
        rdy  = !blk && srdy;
        sv   = '0;
        if (m_cmd_valid && !blk && sel < NS) sv[sel] = 1'b1;
        chk("cmd_ready", {31'd0, m_cmd_ready}, {31'd0, rdy});
        chk("s_cmd_valid", 32'(s_cmd_valid), 32'(sv));
        chk("s_cmd_addr", s_cmd_addr, m_cmd_addr);
        chk("s_cmd_wdata", s_cmd_wdata, m_cmd_wdata);
        chk("s_cmd_fields", {26'd0, s_cmd_wr, s_cmd_instr, s_cmd_be}, {26'd0, m_cmd_wr, m_cmd_instr, m_cmd_be});
        rsp = q_exp.size() > 0 && q_exp[0].due == cyc;
        chk("rsp_ready", {31'd0, m_rsp_ready}, {31'd0, rsp});
        if (rsp) begin
            chk("rsp_rdata", m_rsp_rdata, q_exp[0].data);
            void'(q_exp.pop_front());
        end
        last_rsp = m_rsp_ready;
        chk("void_cnt", {16'd0, void_cnt}, {16'd0, vcnt});
        chk("void_addr", void_addr, vaddr);
        chk("void_irq", {31'd0, void_irq}, {31'd0, irq_exp});
        acc     = m_cmd_valid && rdy;
        irq_exp = acc && sel == NS;
        if (irq_exp) begin
            vaddr = m_cmd_addr;
            if (vcnt != 16'hFFFF) vcnt++;
        end
        if (acc && !m_cmd_wr) begin
            d = (sel == NS) ? VDATA : $urandom;
            q_exp.push_back('{due: cyc + lat[sel], data: d});
            if (sel < NS) sq[sel].push_back('{due: cyc + lat[sel], data: d});
            owner = sel;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_cmd(input bit wr, input logic [31:0] addr);
        m_cmd_valid = 1'b1;
        m_cmd_wr    = wr;
        m_cmd_addr  = addr;
        m_cmd_wdata = $urandom;
        m_cmd_be    = 4'($urandom);
        m_cmd_instr = 1'($urandom);
    endtask

    task automatic do_cmd(input bit wr, input logic [31:0] addr, output int waits);
        bit acc;
        waits = 0;
        set_cmd(wr, addr);
        tick(acc);
        while (!acc && waits < 40) begin
            waits++;
            tick(acc);
        end
        chk("cmd_accept_timeout", {31'd0, acc}, 32'd1);
        m_cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        m_cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q_exp.size() > 0 && k < 60) begin
            idle(1);
            k++;
        end
        chk("drain_timeout", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w, n;
        bit  acc;
        logic [31:0] a;

        lat[0] = 2; lat[1] = 3; lat[NS] = 1;
        cyc = 0; owner = 0; vcnt = '0; vaddr = '0; irq_exp = 1'b0; last_rsp = 1'b0;
        reset_ = 1'b0;
        m_cmd_valid = 1'b0; m_cmd_wr = 1'b0; m_cmd_instr = 1'b0;
        m_cmd_addr = '0; m_cmd_wdata = '0; m_cmd_be = '0;
        s_cmd_ready = '1; s_rsp_ready = '0; s_rsp_rdata = '0;
        #1;
        chk("reset_rsp_ready", {31'd0, m_rsp_ready}, 32'd0);
        chk("reset_s_cmd_valid", 32'(s_cmd_valid), 32'd0);
        chk("reset_void_cnt", {16'd0, void_cnt}, 32'd0);
        chk("reset_void_addr", void_addr, 32'd0);
        chk("reset_void_irq", {31'd0, void_irq}, 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // single read to slave 0
        do_cmd(1'b0, 32'h0000_0100, w);
        chk("t1_no_wait", 32'(w), 32'd0);
        drain();

        // void reads: response one cycle later, back-to-back stays back-to-back
        do_cmd(1'b0, 32'h8000_0000, w);
        idle(1);
        chk("t4_rsp_next", {31'd0, last_rsp}, 32'd1);
        chk("t4_void_cnt", {16'd0, void_cnt}, 32'd1);
        chk("t4_void_addr", void_addr, 32'h8000_0000);
        do_cmd(1'b0, 32'h8000_0010, w);
        do_cmd(1'b0, 32'h8000_0020, w);
        idle(2);

        // outstanding limit with a slow slave 0
        lat[0] = 6;
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, 32'(4 * i), w);
            chk("t2_burst_no_wait", 32'(w), 32'd0);
        end
        do_cmd(1'b0, 32'h0000_0010, w);
        chk("t2_fifth_stall", 32'(w), 32'd3);
        drain();

        // read owner blocks other-slave reads, writes pass
        do_cmd(1'b0, 32'h0000_0200, w);
        set_cmd(1'b0, 32'hF000_0040);
        tick(acc);
        chk("t3_read_blocked", {31'd0, acc}, 32'd0);
        set_cmd(1'b1, 32'hF000_0044);
        tick(acc);
        chk("t3_write_passes", {31'd0, acc}, 32'd1);
        do_cmd(1'b0, 32'hF000_0040, w);
        chk("t3_read_wait", 32'(w), 32'd4);
        drain();
        lat[0] = 2;

        // slave backpressure on a write
        s_cmd_ready[0] = 1'b0;
        set_cmd(1'b1, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            chk("t5_held", {31'd0, acc}, 32'd0);
        end
        s_cmd_ready[0] = 1'b1;
        tick(acc);
        chk("t5_accept", {31'd0, acc}, 32'd1);
        m_cmd_valid = 1'b0;
        idle(1);

        // void counter saturation via a long run of void writes
        n = 32'(16'hFFFF - vcnt) + 5;
        set_cmd(1'b1, 32'h8000_1230);
        repeat (n) @(posedge clk);
        #1;
        m_cmd_valid = 1'b0;
        cyc += n;
        vcnt = 16'hFFFF; vaddr = 32'h8000_1230; irq_exp = 1'b1;
        idle(1);
        do_cmd(1'b1, 32'h8000_4440, w);
        idle(1);
        chk("t5_saturated", {16'd0, void_cnt}, 32'h0000_FFFF);

        // random traffic
        lat[0] = 2; lat[1] = 3;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 2))
                0:       a = $urandom & 32'h0000_1FFF;
                1:       a = 32'hF000_0000 | ($urandom & 32'h0000_0FFF);
                default: a = $urandom;
            endcase
            set_cmd(1'($urandom), a);
            m_cmd_valid = ($urandom_range(0, 9) < 7);
            s_cmd_ready = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
            tick(acc);
        end
        m_cmd_valid = 1'b0;
        s_cmd_ready = '1;
        drain();
        idle(1);

        // reset in the middle of a read burst
        do_cmd(1'b0, 32'h0000_0400, w);
        do_cmd(1'b0, 32'h0000_0404, w);
        reset_ = 1'b0;
        s_rsp_ready = '0;
        #1;
        chk("t6_rsp_cleared", {31'd0, m_rsp_ready}, 32'd0);
        chk("t6_void_cnt_cleared", {16'd0, void_cnt}, 32'd0);
        chk("t6_void_addr_cleared", void_addr, 32'd0);
        q_exp.delete();
        for (int s = 0; s < NS; s++) sq[s].delete();
        vcnt = '0; vaddr = '0; irq_exp = 1'b0; owner = 0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        cyc += 10;
        do_cmd(1'b0, 32'hF000_0080, w);
        chk("t6_other_slave_free", 32'(w), 32'd0);
        drain();
        do_cmd(1'b0, 32'h0000_0100, w);
        chk("t6_read_no_wait", 32'(w), 32'd0);
        drain();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
